// File: rtl/fc1_pkg.sv
// -----------------------------------------------------------------------------
// fc1_pkg
// Shared constants and types for the fc1 compute engine.
//   - Layer geometry: 784 input features, 16 neurons computed in parallel.
//   - Arithmetic widths for weights, activations, accumulators and outputs.
//   - FSM state encoding and the packed-lane word types.
// -----------------------------------------------------------------------------
package fc1_pkg;

    localparam int NUM_INPUTS   = 784;
    localparam int NUM_NEURONS  = 16;
    localparam int WEIGHT_WIDTH = 8;
    localparam int ACT_WIDTH    = 8;
    localparam int ACC_WIDTH    = 32;
    localparam int OUT_WIDTH    = 8;
    localparam int OUT_SHIFT    = 7;
    localparam int ADDR_WIDTH   = $clog2(NUM_INPUTS);

    // Full-precision width of one signed weight x activation product
    localparam int PROD_WIDTH   = WEIGHT_WIDTH + ACT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        FINISH = 2'd2,
        OUTPUT = 2'd3
    } fc1_state_e;

    // Packed-lane words: lane i lives in bits [i*W +: W]
    typedef logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] weight_word_t;
    typedef logic [NUM_NEURONS*OUT_WIDTH-1:0]    out_word_t;

endpackage

// File: rtl/fc1_requant.sv
// -----------------------------------------------------------------------------
// fc1_requant
// Purely combinational requantisation of one neuron lane:
//   s = (acc + bias) >>> OUT_SHIFT   (floor rounding)
//   y = 0 if s < 0, 127 if s > 127, else s[7:0]
// Ports:
//   acc   in  ACC_WIDTH  signed accumulated dot product
//   bias  in  ACC_WIDTH  signed bias for this lane
//   y     out OUT_WIDTH  ReLU'd and saturated activation
// -----------------------------------------------------------------------------
module fc1_requant
    import fc1_pkg::*;
(
    input  logic [ACC_WIDTH-1:0] acc,
    input  logic [ACC_WIDTH-1:0] bias,
    output logic [OUT_WIDTH-1:0] y
);

    // One guard bit so an extreme bias cannot wrap the sum
    localparam int SUM_WIDTH = ACC_WIDTH + 1;
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
        SUM_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);

    logic signed [SUM_WIDTH-1:0] sum;
    logic signed [SUM_WIDTH-1:0] shifted;

    always_comb begin
        sum     = $signed({acc[ACC_WIDTH-1], acc}) + $signed({bias[ACC_WIDTH-1], bias});
        shifted = sum >>> OUT_SHIFT;
        y       = '0;
        if (shifted < 0) begin
            y = '0;
        end else if (shifted > SAT_MAX) begin
            y = OUT_WIDTH'(SAT_MAX);
        end else begin
            y = shifted[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fc1_mac_engine.sv
// -----------------------------------------------------------------------------
// fc1_mac_engine
// fc1 layer compute engine: streams 784 signed activations against the packed
// per-feature weight word from the ROM, accumulates 16 dot products in
// parallel, then applies bias, shift, ReLU and saturation and hands one packed
// result word downstream.
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin an inference (honoured only in IDLE)
//   busy       out  high from accepted start until the output handshake
//   x_data     in   signed activation;  x_valid/x_ready handshake
//   rom_addr   out  feature index to the combinational weight ROM
//   rom_data   in   packed weights, neuron i in [i*8 +: 8]
//   bias_data  in   packed signed biases, neuron i in [i*32 +: 32]
//   y_data     out  packed results, neuron i in [i*8 +: 8]; y_valid/y_ready
// -----------------------------------------------------------------------------
module fc1_mac_engine
    import fc1_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    output logic                                busy,
    input  logic [ACT_WIDTH-1:0]                x_data,
    input  logic                                x_valid,
    output logic                                x_ready,
    output logic [ADDR_WIDTH-1:0]               rom_addr,
    input  logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] rom_data,
    input  logic [NUM_NEURONS*ACC_WIDTH-1:0]    bias_data,
    output logic [NUM_NEURONS*OUT_WIDTH-1:0]    y_data,
    output logic                                y_valid,
    input  logic                                y_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);

    fc1_state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]       cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q    [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] acc_d    [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] prod_ext [NUM_NEURONS];
    out_word_t                   y_data_q, y_data_d;
    out_word_t                   lane_y;
    logic                        acc_clr;
    logic                        acc_en;

    // Per-lane multiply and requantisation
    generate
        for (genvar gi = 0; gi < NUM_NEURONS; gi++) begin : g_lane
            logic signed [PROD_WIDTH-1:0] prod;

            assign prod = $signed(x_data) * $signed(rom_data[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
            assign prod_ext[gi] = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

            fc1_requant u_requant (
                .acc  (acc_q[gi]),
                .bias (bias_data[gi*ACC_WIDTH +: ACC_WIDTH]),
                .y    (lane_y[gi*OUT_WIDTH +: OUT_WIDTH])
            );
        end
    endgenerate

    // Next-state / control
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        y_data_d = y_data_q;
        acc_clr  = 1'b0;
        acc_en   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_clr = 1'b1;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (x_valid) begin
                    acc_en = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        state_d = FINISH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FINISH: begin
                // Accumulators are final here; capture the requantised lanes
                y_data_d = lane_y;
                state_d  = OUTPUT;
            end
            OUTPUT: begin
                // start is deliberately not looked at here, even on the
                // handshake cycle
                if (y_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            acc_d[i] = acc_q[i];
            if (acc_clr) begin
                acc_d[i] = '0;
            end else if (acc_en) begin
                acc_d[i] = acc_q[i] + prod_ext[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            y_data_q <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            y_data_q <= y_data_d;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign busy     = (state_q != IDLE);
    assign x_ready  = (state_q == ACCUM);
    assign y_valid  = (state_q == OUTPUT);
    assign rom_addr = cnt_q;
    assign y_data   = y_data_q;

endmodule

// File: tb/tb_fc1_mac_engine.sv
module tb_fc1_mac_engine;
    import fc1_pkg::*;

    logic                                clk = 1'b0;
    logic                                rst_n;
    logic                                start;
    logic                                busy;
    logic [ACT_WIDTH-1:0]                x_data;
    logic                                x_valid;
    logic                                x_ready;
    logic [ADDR_WIDTH-1:0]               rom_addr;
    logic [NUM_NEURONS*WEIGHT_WIDTH-1:0] rom_data;
    logic [NUM_NEURONS*ACC_WIDTH-1:0]    bias_data;
    logic [NUM_NEURONS*OUT_WIDTH-1:0]    y_data;
    logic                                y_valid;
    logic                                y_ready;

    always #5 clk = ~clk;

    fc1_mac_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .x_data    (x_data),
        .x_valid   (x_valid),
        .x_ready   (x_ready),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .bias_data (bias_data),
        .y_data    (y_data),
        .y_valid   (y_valid),
        .y_ready   (y_ready)
    );

    // Test data: weight ROM contents, activation stream, biases
    logic signed [WEIGHT_WIDTH-1:0] w_mem [NUM_INPUTS][NUM_NEURONS];
    logic signed [ACT_WIDTH-1:0]    x_mem [NUM_INPUTS];
    logic signed [ACC_WIDTH-1:0]    bias_mem [NUM_NEURONS];

    always_comb begin
        rom_data = '0;
        for (int n = 0; n < NUM_NEURONS; n++)
            rom_data[n*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_mem[rom_addr][n];
    end

    always_comb begin
        bias_data = '0;
        for (int n = 0; n < NUM_NEURONS; n++)
            bias_data[n*ACC_WIDTH +: ACC_WIDTH] = bias_mem[n];
    end

    int   checks = 0;
    int   errors = 0;
    int   cycle_cnt = 0;
    int   last_acc_cyc = -100;
    int   txn = 0;
    logic [NUM_NEURONS*OUT_WIDTH-1:0] exp_q [$];
    logic [NUM_NEURONS*OUT_WIDTH-1:0] held;
    logic [NUM_NEURONS*OUT_WIDTH-1:0] exp_word;
    logic stall_flag = 1'b0;
    logic yv_prev = 1'b0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    task automatic chk(input bit ok, input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, want);
        end
    endtask

    // Reference: plain integer dot product, bias, floor division by 2^7, clamp
    function automatic logic [NUM_NEURONS*OUT_WIDTH-1:0] ref_model();
        logic [NUM_NEURONS*OUT_WIDTH-1:0] r;
        longint s;
        r = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            s = longint'(bias_mem[n]);
            for (int f = 0; f < NUM_INPUTS; f++)
                s += longint'(x_mem[f]) * longint'(w_mem[f][n]);
            s = s >>> OUT_SHIFT;
            if (s < 0)        r[n*OUT_WIDTH +: OUT_WIDTH] = 8'd0;
            else if (s > 127) r[n*OUT_WIDTH +: OUT_WIDTH] = 8'd127;
            else              r[n*OUT_WIDTH +: OUT_WIDTH] = 8'(s);
        end
        return r;
    endfunction

    task automatic fill(input int mode);
        for (int n = 0; n < NUM_NEURONS; n++) bias_mem[n] = 0;
        for (int f = 0; f < NUM_INPUTS; f++) begin
            case (mode)
                0: begin
                    x_mem[f] = 8'sd1;
                    for (int n = 0; n < NUM_NEURONS; n++) w_mem[f][n] = 8'sd1;
                end
                1: begin
                    x_mem[f] = 8'sd127;
                    for (int n = 0; n < NUM_NEURONS; n++) w_mem[f][n] = 8'sd0;
                    w_mem[f][0] = 8'sd127;
                    w_mem[f][1] = -8'sd128;
                end
                2: begin
                    x_mem[f] = 8'sd0;
                    for (int n = 0; n < NUM_NEURONS; n++) w_mem[f][n] = 8'($urandom);
                end
                default: begin
                    x_mem[f] = 8'(int'($urandom_range(0, 31)) - 16);
                    for (int n = 0; n < NUM_NEURONS; n++) w_mem[f][n] = 8'($urandom);
                end
            endcase
        end
        if (mode == 2) begin
            bias_mem[3] = 1000;
            bias_mem[4] = -1;
        end else if (mode >= 3) begin
            for (int n = 0; n < NUM_NEURONS; n++)
                bias_mem[n] = 32'(int'($urandom_range(0, 16383)) - 8192);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_flag = 1'b0;
            yv_prev    = 1'b0;
        end else begin
            if (y_valid && !yv_prev)
                chk(cycle_cnt - last_acc_cyc == 2, "latency", 128'(cycle_cnt - last_acc_cyc), 128'd2);
            if (stall_flag)
                chk(y_valid && (y_data === held), "stall_hold", y_data, held);
            stall_flag = y_valid && !y_ready;
            held       = y_data;
            if (y_valid && y_ready) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_output", y_data, 128'd0);
                end else begin
                    exp_word = exp_q.pop_front();
                    txn++;
                    $display("txn %0d: y_data=%h expected=%h", txn, y_data, exp_word);
                    chk(y_data === exp_word, "y_data", y_data, exp_word);
                end
            end
            yv_prev = y_valid;
        end
    end

    task automatic do_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(negedge clk);
        chk(busy === 1'b0, "idle_before_start", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk(busy && x_ready && rom_addr == 0, "start_accept", {busy, x_ready, 6'd0, 10'(rom_addr)}, {1'b1, 1'b1, 16'd0});
    endtask

    task automatic drive_inputs(input int gap_pct, input bit poke, input int abort_at);
        int f = 0;
        int guard = 0;
        while (f < NUM_INPUTS) begin
            @(posedge clk); #1;
            if (abort_at >= 0 && f == abort_at) begin
                rst_n = 1'b0;
                x_valid = 1'b0;
                start = 1'b0;
                #1;
                chk(!busy && !x_ready && !y_valid, "abort_ctrl", {busy, x_ready, y_valid}, 0);
                chk(rom_addr == 0 && y_data == 0, "abort_data", {10'(rom_addr), y_data}, 0);
                void'(exp_q.pop_back());
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            start = poke && ($urandom_range(0, 99) < 3);
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                x_valid = 1'b0;
                x_data  = 8'($urandom);
            end else begin
                x_valid = 1'b1;
                x_data  = x_mem[f];
            end
            @(negedge clk);
            if (x_valid && x_ready) begin
                chk(rom_addr == ADDR_WIDTH'(f), "rom_addr", 128'(rom_addr), 128'(f));
                if (f == NUM_INPUTS - 1) last_acc_cyc = cycle_cnt;
                f++;
            end
            guard++;
            if (guard > 5000) begin
                chk(1'b0, "input_timeout", 128'(f), 128'(NUM_INPUTS));
                break;
            end
        end
        @(posedge clk); #1;
        x_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_y_valid();
        bit seen = 1'b0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            seen = y_valid;
        end
        chk(seen, "y_valid_timeout", seen, 1);
    endtask

    task automatic finish_output(input int stall);
        bit idle = 1'b0;
        wait_y_valid();
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                start = (i == 3);
            end
            @(posedge clk); #1;
            start = 1'b0;
            y_ready = 1'b1;
        end
        for (int t = 0; t < 20 && !idle; t++) begin
            @(negedge clk);
            idle = !busy;
        end
        chk(idle, "idle_timeout", idle, 1);
    endtask

    task automatic run_one(input int gap_pct, input bit poke, input int stall);
        exp_q.push_back(ref_model());
        do_start();
        drive_inputs(gap_pct, poke, -1);
        finish_output(stall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = '0; y_ready = 1'b1;
        fill(0);
        #1 rst_n = 1'b0;
        #2;
        chk(busy === 1'b0,    "reset_busy",     busy, 0);
        chk(x_ready === 1'b0, "reset_x_ready",  x_ready, 0);
        chk(y_valid === 1'b0, "reset_y_valid",  y_valid, 0);
        chk(y_data === '0,    "reset_y_data",   y_data, 0);
        chk(rom_addr === '0,  "reset_rom_addr", 128'(rom_addr), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // All-ones dot product, saturation/ReLU lanes, bias-only
        fill(0); run_one(0, 1'b0, 0);
        fill(1); run_one(0, 1'b0, 0);
        fill(2); run_one(0, 1'b0, 0);

        // Random data gap-free, then same data with gaps, start pokes, stall
        fill(3); run_one(0, 1'b0, 0);
        y_ready = 1'b0;
        run_one(40, 1'b1, 10);
        y_ready = 1'b1;

        // Reset abort at feature 400, then a clean rerun
        fill(3);
        exp_q.push_back(ref_model());
        do_start();
        drive_inputs(20, 1'b0, 400);
        run_one(0, 1'b0, 0);

        // Back-to-back: start held through the handshake cycle into IDLE
        fill(0);
        exp_q.push_back(ref_model());
        do_start();
        drive_inputs(0, 1'b0, -1);
        wait_y_valid();
        fill(1);
        exp_q.push_back(ref_model());
        start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk(busy === 1'b0, "start_in_handshake_ignored", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk(busy && rom_addr == 0, "b2b_start", {busy, 10'(rom_addr)}, {1'b1, 10'd0});
        drive_inputs(0, 1'b0, -1);
        finish_output(0);

        repeat (5) @(posedge clk);
        chk(exp_q.size() == 0, "pending_expected", 128'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
